// File: rtl/outport_pkg.sv
// Shared definitions for the output-port scanner: digit index type, blank pattern, hex segment table.
// Latency: none (constants and types only).
// Backpressure: none.
package outport_pkg;

   // Index of the digit currently being driven; 0 is the rightmost digit
   typedef logic [1:0] digit_idx_t;

   // All segments off (segments are active-low)
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a} pattern for each hex value, entry [n] drives nibble n
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg
   import outport_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/outport_scanner.sv
// Multiplexed 4-digit hex display of a 16-bit snapshot of CPU output ports {s1,s0} or {s3,s2}.
// Latency: seg/an registered, one cycle behind the scan state; snapshot reloads only at frame boundaries.
// Backpressure: none, free-running scan; hold freezes the snapshot. Optional macro LEADING_ZERO_BLANK_EN.
module outport_scanner
   import outport_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] s0,
   input  logic [7:0] s1,
   input  logic [7:0] s2,
   input  logic [7:0] s3,
   input  logic       sel,
   input  logic       hold,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       changed
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] presc;
   digit_idx_t    idx;
   logic [15:0]   snap;
   logic [15:0]   snap_new;
   logic          tc;
   logic          load;
   logic [3:0]    nib;
   logic [6:0]    hex_seg;
   logic          blank;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;

   assign tc       = (presc == CW'(SCAN_DIV - 1));
   // Frame boundary is the last prescaler tick of digit 3; reloading only here keeps a frame coherent
   assign load     = tc && (idx == 2'd3) && !hold;
   assign snap_new = sel ? {s3, s2} : {s1, s0};

   // Pick the nibble and the anode for the digit currently being scanned
   always_comb begin
      nib    = snap[3:0];
      an_nxt = 4'b1110;
      case (idx)
         2'd0: begin nib = snap[3:0];   an_nxt = 4'b1110; end
         2'd1: begin nib = snap[7:4];   an_nxt = 4'b1101; end
         2'd2: begin nib = snap[11:8];  an_nxt = 4'b1011; end
         2'd3: begin nib = snap[15:12]; an_nxt = 4'b0111; end
         default: begin nib = snap[3:0]; an_nxt = 4'b1110; end
      endcase
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nib),
      .seg    (hex_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Blank a digit when it and everything to its left are zero; digit 0 always shows
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1: blank = (snap[15:4] == 12'h000);
         2'd2: blank = (snap[15:8] == 8'h00);
         2'd3: blank = (snap[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   assign seg_nxt = blank ? SEG_BLANK : hex_seg;

   // Scan state, snapshot and registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         presc   <= '0;
         idx     <= 2'd0;
         snap    <= 16'h0000;
         seg     <= SEG_BLANK;
         an      <= 4'b1111;
         changed <= 1'b0;
      end else begin
         seg     <= seg_nxt;
         an      <= an_nxt;
         changed <= load && (snap_new != snap);
         if (tc) begin
            presc <= '0;
            idx   <= idx + 2'd1;
            if (load) begin
               snap <= snap_new;
            end
         end else begin
            presc <= presc + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_outport_scanner.sv
// Directed bench for outport_scanner with SCAN_DIV=4 (one frame = 16 cycles).
// Expected digit patterns are hand-computed per frame; optional LEADING_ZERO_BLANK_EN changes zero-digit patterns.
// Outputs sampled 1 time unit after each rising edge.
module tb_outport_scanner;

   localparam logic [6:0] H0 = 7'b1000000;
   localparam logic [6:0] H1 = 7'b1111001;
   localparam logic [6:0] H2 = 7'b0100100;
   localparam logic [6:0] H3 = 7'b0110000;
   localparam logic [6:0] H4 = 7'b0011001;
   localparam logic [6:0] H5 = 7'b0010010;
   localparam logic [6:0] H6 = 7'b0000010;
   localparam logic [6:0] H7 = 7'b1111000;
   localparam logic [6:0] H9 = 7'b0010000;
   localparam logic [6:0] HA = 7'b0001000;
   localparam logic [6:0] HB = 7'b0000011;
   localparam logic [6:0] HC = 7'b1000110;
   localparam logic [6:0] HF = 7'b0001110;
   localparam logic [6:0] OFF = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] ZB = OFF;
`else
   localparam logic [6:0] ZB = H0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] s0, s1, s2, s3;
   logic       sel, hold;
   logic [6:0] seg;
   logic [3:0] an;
   logic       changed;

   int checks = 0;
   int failures = 0;

   outport_scanner #(.SCAN_DIV(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .s3      (s3),
      .sel     (sel),
      .hold    (hold),
      .seg     (seg),
      .an      (an),
      .changed (changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs from just after a frame-boundary edge; e0..e3 are the digit patterns of the frame.
   // act_at >= 0 applies sel=act_sel after that many ticks.
   task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3, input logic exp_chg,
                              input int nticks, input int act_at, input logic act_sel);
      logic [6:0] e [4];
      logic [3:0] a [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      a[0] = 4'b1110; a[1] = 4'b1101; a[2] = 4'b1011; a[3] = 4'b0111;
      check($sformatf("%s changed_at_load", tag), {15'd0, changed}, {15'd0, exp_chg});
      for (int t = 1; t <= nticks; t++) begin
         if (t - 1 == act_at) sel = act_sel;
         tick();
         check($sformatf("%s an t%0d", tag, t), {12'd0, an}, {12'd0, a[(t-1)/4]});
         check($sformatf("%s seg t%0d", tag, t), {9'd0, seg}, {9'd0, e[(t-1)/4]});
         if (t < 16) check($sformatf("%s changed t%0d", tag, t), {15'd0, changed}, 16'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check($sformatf("%s seg", tag), {9'd0, seg}, {9'd0, OFF});
      check($sformatf("%s an", tag), {12'd0, an}, 16'h000F);
      check($sformatf("%s changed", tag), {15'd0, changed}, 16'd0);
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; hold = 1'b0;
      s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
      tick(); tick(); tick();
      check_reset_outputs("reset");
      reset = 1'b0;

      // Zero snapshot scan: four cycles per digit, rightmost first
      check_frame("f0_zero", H0, ZB, ZB, ZB, 1'b0, 16, -1, 1'b0);
      s0 = 8'h3A; s1 = 8'hF1;
      check_frame("f1_zero", H0, ZB, ZB, ZB, 1'b0, 16, -1, 1'b0);
      // Snapshot F13A loaded at the boundary
      hold = 1'b1; s0 = 8'h55;
      check_frame("f2_f13a", HA, H3, H1, HF, 1'b1, 16, -1, 1'b0);
      // Held: boundary load skipped
      hold = 1'b0;
      check_frame("f3_hold", HA, H3, H1, HF, 1'b0, 16, -1, 1'b0);
      // Released: F155; sel flips mid-frame but display must not change yet
      s2 = 8'h12; s3 = 8'h34;
      check_frame("f4_f155", H5, H5, H1, HF, 1'b1, 16, 8, 1'b1);
      // Pair switch lands at the boundary: 3412
      sel = 1'b0; s1 = 8'h00; s0 = 8'h07;
      check_frame("f5_3412", H2, H1, H4, H3, 1'b1, 16, -1, 1'b0);
      // 0007: leading zeros blank when enabled
      s1 = 8'h10;
      check_frame("f6_0007", H7, ZB, ZB, ZB, 1'b1, 16, -1, 1'b0);
      // 1007: inner zeros never blank
      s3 = 8'h9C; s2 = 8'hB6;
      check_frame("f7_1007", H7, H0, H0, H1, 1'b1, 16, -1, 1'b0);
      // Equal reload gives no pulse; sel changes in the boundary cycle itself
      check_frame("f8_same", H7, H0, H0, H1, 1'b0, 16, 15, 1'b1);
      // 9CB6 captured from the boundary cycle; stop while digit 2 is lit
      check_frame("f9_9cb6", H6, HB, HC, H9, 1'b1, 10, -1, 1'b1);
      reset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      reset = 1'b0;
      check_frame("f10_restart", H0, ZB, ZB, ZB, 1'b0, 16, -1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/outport_scanner.md
OUTPORT_SCANNER -- requirements
Module: outport_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit stays lit (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports s0,s1,s2,s3  input  8 each  CPU output ports from monociclo.
REQ-005 SHALL have port sel  input  1  pair select: 0 shows {s1,s0}, 1 shows {s3,s2}.
REQ-006 SHALL have port hold  input  1  freezes the displayed snapshot while high.
REQ-007 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port an  output  4  active-low digit enables; an[0] is the rightmost digit.
REQ-009 SHALL have port changed  output  1  one-cycle pulse when a snapshot load alters the shown value.

Function
REQ-010 SHALL keep a 16-bit snapshot; digit k shows snapshot nibble k: digits 0-1 from s0/s2, digits 2-3 from s1/s3.
REQ-011 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-012 SHALL drive exactly one an bit low per cycle, matching the digit index; seg and an SHALL be registered and update in the same cycle.
REQ-013 SHALL load the snapshot only at frame boundary (terminal count with index 3), selecting the pair by sel sampled in that cycle, so no frame shows a mix of old and new nibbles.
REQ-014 SHALL skip the load at a frame boundary when hold=1; the snapshot, sel effect and changed all stay frozen.
REQ-015 SHALL pulse changed high for exactly the cycle after a load whose new value differs from the old; equal reloads give no pulse.
REQ-016 SHALL decode hex 0-F: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110 (full table in package).
REQ-017 SHALL, when s-inputs and sel change at a boundary in the same cycle, capture the values present in that cycle.

Reset
REQ-018 SHALL, while reset is high, force seg=1111111, an=1111, changed=0, prescaler=0, index=0, snapshot=0000h.
REQ-019 SHALL, in the first cycle after reset falls, drive an=1110 and seg=1000000 (digit 0 showing 0).
REQ-020 SHALL abort any scan in progress on mid-operation reset; no changed pulse SHALL result from reset.

Configuration
REQ-021 SHALL support macro LEADING_ZERO_BLANK_EN: when defined, digits 3, 2, 1 drive seg=1111111 while they and every higher digit are zero (digit 0 is never blanked); when undefined, all four digits always show hex.
REQ-022 SHALL keep an scan timing identical with or without the macro.

Structure
REQ-023 SHALL place the hex-to-segment table, the SEG_BLANK constant and the digit-index type in shared package outport_pkg.
REQ-024 SHALL use one sub-module, hex_to_seg (4-bit nibble in, 7-bit active-low segments out, combinational).

Verification (bench uses SCAN_DIV=4)
REQ-025 SHALL check: reset then release -> an sequence 1110,1101,1011,0111 repeating, each held 4 cycles, seg=1000000 throughout.
REQ-026 SHALL check: s0=3Ah, s1=F1h, sel=0 before a boundary -> next frame digits 0..3 show A,3,1,F; changed pulses once.
REQ-027 SHALL check: hold=1, s0 changed to 55h -> display unchanged and no pulse; hold=0 -> 5,5 shown from the next frame.
REQ-028 SHALL check: sel toggled mid-frame with s2=12h, s3=34h -> switch occurs only at the frame boundary, then 2,1,4,3 is shown.
REQ-029 SHALL check: LEADING_ZERO_BLANK_EN defined, s1=00h, s0=07h -> digits 3,2,1 show 1111111 and digit 0 shows 1111000; s1=10h -> digits 3,2,1 show 1,0,0.
REQ-030 SHALL check: reset asserted during digit 2 -> next cycle all outputs at reset values, then scan restarts at digit 0.
